// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - step encoding, speed limits and x4 decode helpers for quad_speed_counter
package quad_pkg;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILLEGAL
  } quad_step_t;

  localparam logic signed [15:0] SPEED_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SPEED_MIN = 16'sh8000;

  // Cycles of decode suppression after reset: two sync stages plus the first decode compare.
  localparam int SYNC_PRIME_CYCLES = 3;

  // Classify one prev->cur transition of the Gray-coded {A,B} pair.
  function automatic quad_step_t quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    quad_step_t step;
    case ({prev, cur})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = STEP_FWD;
      4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step = STEP_REV;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step = STEP_ILLEGAL;
      default:                                step = STEP_NONE;
    endcase
    return step;
  endfunction

  // Add a -1/0/+1 step to a 16-bit signed count, clamping instead of wrapping.
  function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                 input logic signed [1:0]  d);
    logic [16:0] sum;
    sum = {a[15], a} + {{15{d[1]}}, d};
    if (sum[16] != sum[15]) begin
      return sum[16] ? SPEED_MIN : SPEED_MAX;
    end
    return sum[15:0];
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// rtl/quad_input_filter.sv - per-channel 2-flop synchronizer with glitch filter (built when QUAD_FILTER_EN gives FILT_LEN > 0)
module quad_input_filter #(
  parameter int FILT_LEN = 0
) (
  input  logic theClock,
  input  logic theReset,
  input  logic pin,
  output logic level
);

  logic sync1;
  logic sync2;

  // Bring the asynchronous encoder pin into the theClock domain.
  always_ff @(posedge theClock or posedge theReset) begin
    if (theReset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  generate
    if (FILT_LEN > 0) begin : g_filt
      localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

      logic [CNT_W-1:0] stable_cnt;
      logic             filt;

      // Adopt the synced value only once it has differed from the output for FILT_LEN cycles in a row.
      always_ff @(posedge theClock or posedge theReset) begin
        if (theReset) begin
          stable_cnt <= '0;
          filt       <= 1'b0;
        end else if (sync2 == filt) begin
          stable_cnt <= '0;
        end else if (stable_cnt == CNT_W'(FILT_LEN - 1)) begin
          stable_cnt <= '0;
          filt       <= sync2;
        end else begin
          stable_cnt <= stable_cnt + CNT_W'(1);
        end
      end

      assign level = filt;
    end else begin : g_bypass
      assign level = sync2;
    end
  endgenerate

endmodule

// File: rtl/quad_speed_counter.sv
// rtl/quad_speed_counter.sv - x4 quadrature decoder with windowed signed speed word; QUAD_FILTER_EN adds input glitch filtering
module quad_speed_counter
  import quad_pkg::*;
#(
  parameter int WINDOW_CYCLES = 500000,
  parameter int FILT_LEN      = 4
) (
  input  logic        theClock,
  input  logic        theReset,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enable,
  output logic [15:0] speed,
  output logic        speed_valid,
  output logic [7:0]  illegal_cnt
);

`ifdef QUAD_FILTER_EN
  localparam int FILTER_ON = 1;
`else
  localparam int FILTER_ON = 0;
`endif

  // Filter depth actually built; zero makes the channel stage a plain synchronizer.
  localparam int FILT_STAGES  = FILT_LEN * FILTER_ON;
  localparam int PRIME_CYCLES = SYNC_PRIME_CYCLES + FILT_STAGES;
  localparam int PRIME_W      = $clog2(PRIME_CYCLES + 1);
  localparam int WIN_W        = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  logic               a_lvl;
  logic               b_lvl;
  logic [1:0]         cur;
  logic [1:0]         prev;
  logic [PRIME_W-1:0] prime_cnt;
  logic               primed;
  quad_step_t         step_kind;
  logic signed [1:0]  step_val;
  logic signed [15:0] acc;
  logic signed [15:0] acc_next;
  logic [WIN_W-1:0]   win_cnt;

  quad_input_filter #(.FILT_LEN(FILT_STAGES)) u_filt_a (
    .theClock (theClock),
    .theReset (theReset),
    .pin      (enc_a),
    .level    (a_lvl)
  );

  quad_input_filter #(.FILT_LEN(FILT_STAGES)) u_filt_b (
    .theClock (theClock),
    .theReset (theReset),
    .pin      (enc_b),
    .level    (b_lvl)
  );

  assign cur    = {a_lvl, b_lvl};
  assign primed = (prime_cnt == PRIME_W'(PRIME_CYCLES));

  // Decode this cycle's step; forced to none until the input pipeline has filled after reset.
  always_comb begin
    step_kind = STEP_NONE;
    if (primed) begin
      step_kind = quad_decode(prev, cur);
    end
    case (step_kind)
      STEP_FWD: step_val = 2'sb01;
      STEP_REV: step_val = 2'sb11;
      default:  step_val = 2'sb00;
    endcase
    acc_next = sat_add(acc, step_val);
  end

  // Track the previous position, count out the priming cycles and tally illegal jumps regardless of enable.
  always_ff @(posedge theClock or posedge theReset) begin
    if (theReset) begin
      prev        <= 2'b00;
      prime_cnt   <= '0;
      illegal_cnt <= 8'd0;
    end else begin
      prev <= cur;
      if (!primed) begin
        prime_cnt <= prime_cnt + PRIME_W'(1);
      end
      if (step_kind == STEP_ILLEGAL && illegal_cnt != 8'hFF) begin
        illegal_cnt <= illegal_cnt + 8'd1;
      end
    end
  end

  // Accumulate steps over each window and publish the total (including the terminal-cycle step) at its end.
  always_ff @(posedge theClock or posedge theReset) begin
    if (theReset) begin
      win_cnt     <= '0;
      acc         <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
    end else if (!enable) begin
      win_cnt     <= '0;
      acc         <= '0;
      speed_valid <= 1'b0;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt     <= '0;
      acc         <= '0;
      speed       <= acc_next;
      speed_valid <= 1'b1;
    end else begin
      win_cnt     <= win_cnt + WIN_W'(1);
      acc         <= acc_next;
      speed_valid <= 1'b0;
    end
  end

endmodule
